// File: rtl/seg_display_arbiter.sv
// Seven-segment display arbiter: owns digit scanning and time-shares the
// 4-digit display between requesters, one owner per dwell window, with
// urgent preemption and a blank frame on every handover.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | nobody owns the display; blank; wait for a request at fb
//  OWN    | one source owns the display; its digits are scanned out
//  SWITCH | handover blank frame; at next fb arbitrate like IDLE
module seg_display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DWELL_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    urgent,
    input  logic [NUM_REQ*28-1:0] src_seg,
    output logic [NUM_REQ-1:0]    grant,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  frame_done
);
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW_W  = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0]  DWELL_INIT = DW_W'(DWELL_FRAMES - 1);
    localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } stateT;

    stateT              state, stateNext;
    logic [PS_W-1:0]    prescaler;
    logic [1:0]         digit, digitNext;
    logic [DW_W-1:0]    dwell, dwellNext;
    logic [PTR_W-1:0]   owner, ownerNext;
    logic [PTR_W-1:0]   rrPtr, rrPtrNext;
    logic               scanTick, frameBound;
    logic [NUM_REQ-1:0] ownerMask, candidates, others;
    logic [PTR_W-1:0]   arbPick;
    logic               arbFound;
    int                 arbIdx;
    logic [6:0]         digitSeg [NUM_REQ][4];

    // Unpacked view of the source digit bus: digitSeg[source][digit].
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gSrc
        for (genvar gd = 0; gd < 4; gd++) begin : gDig
            assign digitSeg[gi][gd] = src_seg[gi*28 + gd*7 +: 7];
        end
    end

    assign scanTick   = (prescaler == PS_LAST);
    assign frameBound = scanTick && (digit == 2'd3);
    assign digitNext  = digit + 2'd1;
    assign ownerMask  = NUM_REQ'(1) << owner;
    assign grant      = (state == OWN) ? ownerMask : '0;
    assign others     = req & ~grant;

    // Round-robin pick: urgent requesters first, searching from the slot after rrPtr.
    always_comb begin
        candidates = ((req & urgent) != '0) ? (req & urgent) : req;
        arbFound   = 1'b0;
        arbPick    = '0;
        arbIdx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arbIdx = (int'(rrPtr) + k) % NUM_REQ;
            if (!arbFound && candidates[PTR_W'(arbIdx)]) begin
                arbFound = 1'b1;
                arbPick  = PTR_W'(arbIdx);
            end
        end
    end

    // Next-state logic; every ownership decision happens on a frame boundary.
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        rrPtrNext = rrPtr;
        dwellNext = dwell;
        if (frameBound) begin
            unique case (state)
                IDLE, SWITCH: begin
                    if (req != '0) begin
                        stateNext = OWN;
                        ownerNext = arbPick;
                        rrPtrNext = arbPick;
                        dwellNext = DWELL_INIT;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                OWN: begin
                    if (!req[owner]) begin
                        stateNext = SWITCH;
                    end else if ((urgent & others) != '0) begin
                        stateNext = SWITCH;
                    end else if (dwell == '0) begin
                        // sole requester keeps the display without a blank frame
                        if (others != '0) stateNext = SWITCH;
                    end else begin
                        dwellNext = dwell - 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Free-running digit-rate prescaler and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            digit     <= 2'd0;
        end else if (scanTick) begin
            prescaler <= '0;
            digit     <= digitNext;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            rrPtr <= PTR_INIT;
            dwell <= '0;
        end else begin
            state <= stateNext;
            owner <= ownerNext;
            rrPtr <= rrPtrNext;
            dwell <= dwellNext;
        end
    end

    // Pin drive: loads the next digit slot using the post-boundary owner so a
    // new owner lights digit 0 in the same cycle its grant rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= 7'h7F;
            an         <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frameBound;
            if (scanTick) begin
                if (stateNext == OWN) begin
                    an  <= ~(4'b0001 << digitNext);
                    seg <= digitSeg[ownerNext][digitNext];
                end else begin
                    an  <= 4'hF;
                    seg <= 7'h7F;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with a frame-level reference model.
module tb_seg_display_arbiter;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = SD * 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   urgent;
    logic [N*28-1:0] srcSeg;
    logic [N-1:0]   grant;
    logic [6:0]     seg;
    logic [3:0]     an;
    logic           frameDone;

    int testCnt = 0;
    int failCnt = 0;

    // reference model: owner index or -1, last granted source, frames owned so far
    int edgeCnt, mOwner, mLast, mHeld;
    logic [N-1:0] expGrant;
    logic [6:0]   expSeg;
    logic [3:0]   expAn;
    logic         expFd;

    seg_display_arbiter #(
        .NUM_REQ(N), .SCAN_DIV(SD), .DWELL_FRAMES(DF)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .urgent(urgent), .src_seg(srcSeg),
        .grant(grant), .seg(seg), .an(an), .frame_done(frameDone)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick();
        logic [N-1:0] c;
        int r;
        c = ((req & urgent) != 0) ? (req & urgent) : req;
        r = -1;
        for (int k = 1; k <= N; k++) begin
            if (r < 0 && c[(mLast + k) % N]) r = (mLast + k) % N;
        end
        return r;
    endfunction

    task automatic modelReset();
        edgeCnt  = 0;
        mOwner   = -1;
        mLast    = N - 1;
        mHeld    = 0;
        expGrant = '0;
        expSeg   = 7'h7F;
        expAn    = 4'hF;
        expFd    = 1'b0;
    endtask

    // advance the model by one clock edge using the inputs the DUT is about to sample
    task automatic modelEdge();
        int tickNo, dg;
        logic [N-1:0] oth;
        edgeCnt++;
        expFd = 1'b0;
        if (edgeCnt % SD == 0) begin
            tickNo = edgeCnt / SD;
            dg     = tickNo % 4;
            if (dg == 0) begin
                expFd = 1'b1;
                if (mOwner < 0) begin
                    if (req != 0) begin
                        mOwner = pick();
                        mLast  = mOwner;
                        mHeld  = 1;
                    end
                end else begin
                    oth = req & ~(N'(1) << mOwner);
                    if (!req[mOwner] || (urgent & oth) != 0 || (mHeld >= DF && oth != 0))
                        mOwner = -1;
                    else
                        mHeld++;
                end
            end
            if (mOwner >= 0) begin
                expAn  = ~(4'b0001 << dg);
                expSeg = srcSeg[mOwner*28 + dg*7 +: 7];
            end else begin
                expAn  = 4'hF;
                expSeg = 7'h7F;
            end
        end
        expGrant = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        #1;
        check("grant", 32'(grant), 32'(expGrant));
        check("seg", 32'(seg), 32'(expSeg));
        check("an", 32'(an), 32'(expAn));
        check("frame_done", 32'(frameDone), 32'(expFd));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // asynchronous reset: outputs must blank immediately, without a clock edge
    task automatic pulseReset();
        reset = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_fd", 32'(frameDone), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic randomSrc();
        for (int i = 0; i < N; i++) srcSeg[i*28 +: 28] = 28'($urandom);
    endtask

    initial begin
        reset  = 1'b0;
        req    = '0;
        urgent = '0;
        randomSrc();
        @(posedge clk);
        #1;
        pulseReset();

        // single requester, known digit patterns
        req = 4'b0010;
        srcSeg[1*28 +: 28] = {7'h30, 7'h24, 7'h79, 7'h40};
        runCycles(FR * 4);

        // reset mid-frame while owning, then first grant waits for the first boundary
        runCycles(7);
        pulseReset();
        runCycles(FR + 8);

        // two contenders rotate with blank handover frames
        pulseReset();
        req = 4'b0101;
        runCycles(FR * 12);

        // owner drops its request mid-frame
        pulseReset();
        req = 4'b0001;
        runCycles(FR * 2 + 6);
        req = 4'b1000;
        runCycles(FR * 3);

        // urgent preemption during dwell picks the urgent source
        pulseReset();
        req = 4'b0001;
        runCycles(FR + 5);
        req    = 4'b0111;
        urgent = 4'b0100;
        runCycles(FR * 3);
        urgent = '0;

        // sole requester keeps the display past dwell expiry
        pulseReset();
        req = 4'b0001;
        runCycles(FR * 11);

        // owner urgent and urgent without request are both ignored
        pulseReset();
        req    = 4'b0011;
        urgent = 4'b0101;
        runCycles(FR * 9);

        // random traffic
        pulseReset();
        for (int i = 0; i < 2600; i++) begin
            if ($urandom_range(0, 11) == 0) req = N'($urandom);
            if ($urandom_range(0, 13) == 0) urgent = N'($urandom & $urandom);
            if ($urandom_range(0, 5) == 0) randomSrc();
            if ($urandom_range(0, 900) == 0) pulseReset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
